// File: rtl/song_recorder.sv
// Records debounced key presses into 32-bit song rows (eight 4-bit notes per row).
// Optional input debouncing is enabled with `define REC_DEBOUNCE_EN.
module song_recorder #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned SONG_ROWS       = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [7:0]  keys_in,
    input  logic        record_start,
    input  logic        record_stop,
    input  logic        song_select,
    output logic        wr_en,
    output logic [1:0]  wr_addr,
    output logic [31:0] wr_data,
    output logic        wr_slot,
    output logic        busy,
    output logic        done,
    output logic [5:0]  note_count,
    output logic [2:0]  last_key
);

    localparam logic [31:0] PadRow  = 32'h8888_8888;
    localparam logic [1:0]  LastRow = 2'(SONG_ROWS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StRelease,
        StCapture,
        StWrite,
        StDone
    } state_e;

    state_e      state_q;
    logic [31:0] row_q;
    logic [2:0]  note_idx_q;
    logic [1:0]  row_addr_q;
    logic        slot_q;
    logic        stop_q;

    logic [2:0]  press_key;
    logic [4:0]  nib_lsb;
    logic [31:0] row_captured;
    logic        press_ok;
    logic        release_ok;

    // Lowest set bit wins when several keys are held together.
    always_comb begin
        press_key = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (keys_in[i]) press_key = 3'(i);
        end
    end

    assign nib_lsb = {3'd7 - note_idx_q, 2'b00};

    always_comb begin
        row_captured = row_q;
        row_captured[nib_lsb +: 4] = {1'b0, press_key};
    end

`ifdef REC_DEBOUNCE_EN
    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CntW-1:0] db_cnt_q;
    logic [CntW-1:0] db_run;
    logic [7:0]      keys_last_q;
    logic            stable;

    // db_run is the length of the current run of identical samples, including this one.
    always_comb begin
        if (keys_in != keys_last_q) begin
            db_run = CntW'(1);
        end else if (db_cnt_q < CntW'(DEBOUNCE_CYCLES)) begin
            db_run = db_cnt_q + CntW'(1);
        end else begin
            db_run = db_cnt_q;
        end
    end

    assign stable     = (db_run >= CntW'(DEBOUNCE_CYCLES));
    assign press_ok   = stable && (keys_in != 8'd0);
    assign release_ok = stable && (keys_in == 8'd0);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            db_cnt_q    <= '0;
            keys_last_q <= 8'd0;
        end else begin
            db_cnt_q    <= db_run;
            keys_last_q <= keys_in;
        end
    end
`else
    assign press_ok   = (keys_in != 8'd0);
    assign release_ok = (keys_in == 8'd0);
`endif

    assign busy = (state_q != StIdle);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= StIdle;
            row_q      <= PadRow;
            note_idx_q <= 3'd0;
            row_addr_q <= 2'd0;
            slot_q     <= 1'b0;
            stop_q     <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= 2'd0;
            wr_data    <= 32'd0;
            wr_slot    <= 1'b0;
            done       <= 1'b0;
            note_count <= 6'd0;
            last_key   <= 3'd0;
        end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (record_start) begin
                        state_q    <= StRelease;
                        row_q      <= PadRow;
                        note_idx_q <= 3'd0;
                        row_addr_q <= 2'd0;
                        note_count <= 6'd0;
                        slot_q     <= song_select;
                        stop_q     <= 1'b0;
                    end
                end
                StRelease, StCapture: begin
                    if (record_stop) begin
                        // Stop beats a simultaneous press; flush only a partly filled row.
                        if (note_idx_q != 3'd0) begin
                            state_q <= StWrite;
                            stop_q  <= 1'b1;
                            wr_en   <= 1'b1;
                            wr_addr <= row_addr_q;
                            wr_data <= row_q;
                            wr_slot <= slot_q;
                        end else begin
                            state_q <= StDone;
                            done    <= 1'b1;
                        end
                    end else if (state_q == StRelease) begin
                        if (release_ok) state_q <= StCapture;
                    end else if (press_ok) begin
                        row_q      <= row_captured;
                        note_idx_q <= note_idx_q + 3'd1;
                        last_key   <= press_key;
                        if (note_count != 6'd32) note_count <= note_count + 6'd1;
                        if (note_idx_q == 3'd7) begin
                            state_q <= StWrite;
                            wr_en   <= 1'b1;
                            wr_addr <= row_addr_q;
                            wr_data <= row_captured;
                            wr_slot <= slot_q;
                        end else begin
                            state_q <= StRelease;
                        end
                    end
                end
                StWrite: begin
                    row_addr_q <= row_addr_q + 2'd1;
                    row_q      <= PadRow;
                    note_idx_q <= 3'd0;
                    if (stop_q || (row_addr_q == LastRow)) begin
                        state_q <= StDone;
                        done    <= 1'b1;
                    end else begin
                        state_q <= StRelease;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: doc/song_recorder.md
SONG_RECORDER -- requirements
Module: song_recorder

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, 16, number of consecutive stable cycles required for a key press or release; used only with REC_DEBOUNCE_EN.
REQ-002 Parameter: SONG_ROWS, 4, number of 32-bit rows per song; the row address is 2 bits wide.
REQ-003 clk_in  input  1  single system clock; all logic is rising-edge.
REQ-004 rst_in  input  1  asynchronous, active-low reset.
REQ-005 keys_in  input  8  key levels, synchronous to clk_in; bit i high means key i is held.
REQ-006 record_start  input  1  one-cycle start pulse.
REQ-007 record_stop  input  1  one-cycle stop pulse; flushes the partial row.
REQ-008 song_select  input  1  song slot; latched at start.
REQ-009 wr_en  output  1  one-cycle song-RAM write strobe.
REQ-010 wr_addr  output  2  row address for the write.
REQ-011 wr_data  output  32  packed row for the write.
REQ-012 wr_slot  output  1  latched song_select for the write.
REQ-013 busy  output  1  high whenever the state is not IDLE.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 note_count  output  6  notes captured since start; range 0..32.
REQ-016 last_key  output  3  index of the most recently captured key.

Function
REQ-017 Row format: note n (n = 1..8) occupies nibble [35-4n : 32-4n], i.e. note 1 is [31:28].
REQ-018 Nibble encoding: bit 3 = 0 and bits [2:0] = key index for a played note; 4'h8 for an unplayed (padded) slot.
REQ-019 States are IDLE, RELEASE, CAPTURE, WRITE and DONE.
REQ-020 IDLE -> RELEASE on record_start: clear the row, note index, row address and note_count; latch song_select.
REQ-021 RELEASE -> CAPTURE once keys_in == 0; without REC_DEBOUNCE_EN this takes effect on the same edge where keys_in is sampled zero.
REQ-022 CAPTURE: a press is keys_in != 0.
REQ-023 On a press, the lowest set bit index is captured; simultaneous keys resolve lowest-wins.
REQ-024 On a press, the captured index is written into the current nibble at the same edge; note index, note_count and last_key are updated at that edge; next state is RELEASE.
REQ-025 When the 8th nibble of a row is captured, the next state is WRITE instead of RELEASE.
REQ-026 WRITE lasts exactly one cycle: wr_en = 1, wr_addr = current row, wr_data = the complete row.
REQ-027 After WRITE, the row address increments and the row buffer reloads to 32'h8888_8888.
REQ-028 After WRITE, the next state is DONE if the row written was row SONG_ROWS-1; otherwise it is RELEASE.
REQ-029 record_stop in RELEASE or CAPTURE with note index > 0: go to WRITE with the unfilled nibbles already at 4'h8, then go to DONE.
REQ-030 record_stop with note index == 0: go directly to DONE; no write.
REQ-031 record_stop in the same cycle as a press: stop wins and the press is discarded.
REQ-032 DONE lasts one cycle with done = 1, then the state returns to IDLE.
REQ-033 record_start while busy is ignored; record_stop in IDLE, WRITE or DONE is ignored.
REQ-034 wr_addr, wr_data and wr_slot hold their values between writes; consumers use them only when wr_en = 1.
REQ-035 note_count never exceeds 32.

Reset
REQ-036 While rst_in = 0, asynchronously: state = IDLE, wr_en = 0, wr_addr = 0, wr_data = 0, wr_slot = 0, busy = 0, done = 0, note_count = 0, last_key = 0, row buffer = 32'h8888_8888, debounce counter = 0.
REQ-037 A reset asserted mid-record, including during WRITE, aborts the record; no write strobe is issued after release of reset until a new record_start.

Configuration
REQ-038 Macro REC_DEBOUNCE_EN defined: a press requires keys_in nonzero and unchanged for DEBOUNCE_CYCLES consecutive cycles; the capture occurs on the edge completing the count.
REQ-039 Macro REC_DEBOUNCE_EN defined: RELEASE requires keys_in == 0 for DEBOUNCE_CYCLES consecutive cycles.
REQ-040 Macro REC_DEBOUNCE_EN defined: any change of keys_in restarts the count.
REQ-041 Macro REC_DEBOUNCE_EN undefined: presses and releases act on the first sampled cycle; the debounce counter is not built.

Verification (REC_DEBOUNCE_EN undefined unless stated)
REQ-042 Start with song_select = 1; play keys 0,1,2,3,4,5,6,7, releasing between each -> one wr_en with wr_addr = 0, wr_data = 32'h0123_4567, wr_slot = 1; note_count = 8.
REQ-043 Play 32 notes, all key 2 -> four writes at addresses 0..3 with data 32'h2222_2222, then one done pulse; busy falls; note_count = 32.
REQ-044 Play keys 5,3 then record_stop -> one write with 32'h5388_8888 at addr 0, then done.
REQ-045 Assert keys_in = 8'b0110_0000 in CAPTURE -> last_key = 5; holding keys without release captures no further notes.
REQ-046 Pulse record_stop and a press in the same cycle at note index 0 -> no write, done pulse, note_count unchanged.
REQ-047 REC_DEBOUNCE_EN defined, DEBOUNCE_CYCLES = 16: a key 4 glitch of 10 cycles -> no capture; key 4 held 16 cycles -> captured; rst_in low during capture -> no wr_en afterwards.
